rf_writeback_ctrl: RTL and testbench
====================================

Name: rf_writeback_ctrl

Overview:
- Writer and read-guard side of the integer register file: owns the single write port (`rf_wr_*`) and reports operand readiness to issue.
- Arbitrates two writeback sources, ALU results and variable-latency load returns, onto that port.
- Buffers ALU results in a small FIFO and tracks outstanding load destinations in a scoreboard, so issue logic can stall on RAW hazards.

Parameters:
- WIDTH, 32, data width; matches the register file.
- SIZE, 32, number of architectural registers; index width is INDEX_W = $clog2(SIZE).
- FIFO_DEPTH, 4, ALU result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  FIFO can accept; a transfer occurs when alu_valid && alu_ready.
- alu_rd  in  INDEX_W  ALU destination.
- alu_data  in  WIDTH  ALU result.
- ld_issue_valid  in  1  a load was issued this cycle.
- ld_issue_rd  in  INDEX_W  destination of the issued load.
- ld_resp_valid  in  1  load data returning; cannot be back-pressured.
- ld_resp_rd  in  INDEX_W  destination of the returning load.
- ld_resp_data  in  WIDTH  load data.
- rs1_index  in  INDEX_W  operand-1 lookup index.
- rs2_index  in  INDEX_W  operand-2 lookup index.
- rs1_busy  out  1  operand 1 not yet readable.
- rs2_busy  out  1  operand 2 not yet readable.
- rf_wr_en  out  1  register file write enable.
- rf_wr_index  out  INDEX_W  register file write index.
- rf_wr_data  out  WIDTH  register file write data.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, active-high):
  - rf_wr_en=0, rf_wr_index=0, rf_wr_data=0, proto_err=0.
  - Scoreboard cleared; FIFO emptied.
  - alu_ready=1 once reset deasserts.
  - A reset mid-operation discards queued ALU results and all pending-load state.
- ALU path:
  - An accepted ALU result with alu_rd!=0 is pushed into the FIFO.
  - An accepted result with alu_rd==0 is accepted and dropped.
  - alu_ready = !full, combinational from FIFO state only.
- Arbitration, evaluated each cycle:
  - Priority 1: if ld_resp_valid && ld_resp_rd!=0, register the load write.
  - Priority 2: else if the FIFO is non-empty, pop the head and register it.
  - Otherwise rf_wr_en=0.
  - A load response to x0 is consumed with no write.
- Write port timing:
  - rf_wr_* are registered; the source event in cycle N produces rf_wr_en=1 in cycle N+1.
  - The register file commits at the end of cycle N+1.
- Simultaneous push and pop:
  - Push and pop in the same cycle are both allowed, including at full and empty.
  - When the FIFO is full and popped in the same cycle, alu_ready is still 0, because ready does not look ahead.
  - When the FIFO is empty, an ALU result is never bypassed straight to the write port; minimum ALU latency is push in N, pop in N+1, write in N+2.
- Scoreboard (SIZE-1 bits; bit 0 does not exist):
  - ld_issue_valid && ld_issue_rd!=0 sets bit[ld_issue_rd].
  - An accepted ld_resp clears bit[ld_resp_rd].
  - When the same index is issued and responded in the same cycle, the set wins.
  - proto_err is set for: an issue to an already-set bit; a response to a clear bit (the data is still written); or alu_valid && alu_ready with alu_rd!=0 whose scoreboard bit is set (WAW against a pending load; the result is still enqueued).
- Busy, for each of rs1 and rs2:
  - busy=0 when the index is 0.
  - Otherwise busy = scoreboard bit OR any valid FIFO entry with a matching rd OR (rf_wr_en && rf_wr_index==index).
  - The in-flight term of that OR depends on the macro; see Optional Feature.
- Index width: INDEX_W indices are never truncated; indices at or above SIZE are not legal inputs.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined:
  - Adds inputs rf_rd1_data and rf_rd2_data (WIDTH, from the register file read ports) and outputs rs1_data and rs2_data (WIDTH).
  - rsN_data = rf_wr_data when rf_wr_en && rf_wr_index==rsN_index && rsN_index!=0; otherwise rsN_data = rf_rdN_data.
  - The in-flight term is removed from busy.
- When undefined:
  - None of those ports exist.
  - busy includes the in-flight term.

Decomposition:
- Package rf_wb_pkg holds:
  - INDEX_W derivation helper.
  - wb_src_e enum {WB_NONE, WB_LOAD, WB_ALU}, used for the registered write source and debug.
  - Struct wb_entry_t {rd, data}.
- Sub-module rf_wb_fifo: synchronous FIFO of wb_entry_t.
  - Parameter DEPTH.
  - Exposes full, empty, and per-entry valid/rd vectors for the busy compare.

Test Plan:
- ALU only: push rd=5, data=0x1234 in cycle 0 → rf_wr_en=1, index=5, data=0x1234 in cycle 2; rs1_index=5 gives busy=1 in cycles 1-2 and 0 in cycle 3.
- Load priority: load resp (rd=3, 0xAAAA) arrives while the FIFO holds rd=7 → the rd=3 write comes first, then rd=7 on the next cycle; no data loss.
- FIFO full: 4 back-to-back ALU pushes while ld_resp_valid is held high → alu_ready=0 after the 4th push; it rises only after ld_resp_valid drops and the first pop happens.
- Scoreboard: issue rd=9, then respond rd=9 with 0xBEEF 5 cycles later → busy(9)=1 until the response, the write occurs the following cycle, proto_err stays 0.
- Error cases: a response to an idle rd=4, and a second issue to a pending rd → proto_err=1 and stays set until reset.
- x0 and reset: ALU push rd=0 → no write; assert reset with 2 FIFO entries queued → no rf_wr_en after reset, alu_ready=1, all busy=0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_pkg
// Shared types for the register-file writeback controller.
//   index_w()   : index width for a register file of a given size
//   wb_src_e    : source of the registered write (none / load / ALU)
//   wb_entry_t  : one buffered writeback {rd, data} at the default geometry
// ---------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_SIZE  = 32;

    function automatic int index_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    localparam int WB_INDEX_W = index_w(WB_SIZE);

    typedef enum logic [1:0] {
        WB_NONE,
        WB_LOAD,
        WB_ALU
    } wb_src_e;

    typedef struct packed {
        logic [WB_INDEX_W-1:0] rd;
        logic [WB_WIDTH-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl_if
// Bundles every signal of rf_writeback_ctrl except clk/reset.
//   ALU source   : alu_valid/alu_ready/alu_rd/alu_data
//   Load source  : ld_issue_valid/ld_issue_rd, ld_resp_valid/ld_resp_rd/ld_resp_data
//   Read guard   : rs1_index/rs2_index -> rs1_busy/rs2_busy
//   Write port   : rf_wr_en/rf_wr_index/rf_wr_data, proto_err
//   RF_WB_BYPASS_EN adds rf_rd1_data/rf_rd2_data in and rs1_data/rs2_data out.
// Modports: slave = the controller, master = the environment driving it.
// ---------------------------------------------------------------------------
interface rf_writeback_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 32
);
    localparam int INDEX_W = rf_wb_pkg::index_w(SIZE);

    logic               alu_valid;
    logic               alu_ready;
    logic [INDEX_W-1:0] alu_rd;
    logic [WIDTH-1:0]   alu_data;
    logic               ld_issue_valid;
    logic [INDEX_W-1:0] ld_issue_rd;
    logic               ld_resp_valid;
    logic [INDEX_W-1:0] ld_resp_rd;
    logic [WIDTH-1:0]   ld_resp_data;
    logic [INDEX_W-1:0] rs1_index;
    logic [INDEX_W-1:0] rs2_index;
    logic               rs1_busy;
    logic               rs2_busy;
    logic               rf_wr_en;
    logic [INDEX_W-1:0] rf_wr_index;
    logic [WIDTH-1:0]   rf_wr_data;
    logic               proto_err;
`ifdef RF_WB_BYPASS_EN
    logic [WIDTH-1:0]   rf_rd1_data;
    logic [WIDTH-1:0]   rf_rd2_data;
    logic [WIDTH-1:0]   rs1_data;
    logic [WIDTH-1:0]   rs2_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_rd, ld_resp_data,
        input  rs1_index, rs2_index,
        output alu_ready, rs1_busy, rs2_busy,
        output rf_wr_en, rf_wr_index, rf_wr_data, proto_err
`ifdef RF_WB_BYPASS_EN
        , input rf_rd1_data, rf_rd2_data
        , output rs1_data, rs2_data
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_rd, ld_resp_data,
        output rs1_index, rs2_index,
        input  alu_ready, rs1_busy, rs2_busy,
        input  rf_wr_en, rf_wr_index, rf_wr_data, proto_err
`ifdef RF_WB_BYPASS_EN
        , output rf_rd1_data, rf_rd2_data
        , input rs1_data, rs2_data
`endif
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
// Synchronous FIFO of writeback entries. DEPTH must be a power of two >= 2.
//   push/push_entry : enqueue (caller only pushes when !full)
//   pop/head        : head entry, dequeued when pop && !empty
//   full/empty      : occupancy flags
//   ent_valid/ent_rd: per-slot occupancy and destination, for hazard lookup
// ---------------------------------------------------------------------------
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  INDEX_W = WB_INDEX_W,
    parameter type entry_t = wb_entry_t
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  entry_t                          push_entry,
    input  logic                            pop,
    output entry_t                          head,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0]                ent_valid,
    output logic [DEPTH-1:0][INDEX_W-1:0]   ent_rd
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy comes only from the
    // pointers and count, so stale data is never observed and reset stays
    // off the wide datapath.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // NOTE: outputs get a default before the loop so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            // Slot i is live when its distance from the head is below count.
            off          = PTR_W'(i) - rd_ptr;
            ent_valid[i] = (CNT_W'(off) < count);
            ent_rd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl
// Owns the integer register file write port and reports operand readiness.
// Load returns (cannot be stalled) win the port over buffered ALU results;
// a scoreboard of outstanding load destinations drives the RAW busy flags.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : rf_writeback_ctrl_if.slave (ALU, load, lookup, write port)
// Optional macro RF_WB_BYPASS_EN: forwards the in-flight write onto
// rs1_data/rs2_data and drops the in-flight term from busy.
// ---------------------------------------------------------------------------
module rf_writeback_ctrl
    import rf_wb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    rf_writeback_ctrl_if.slave bus
);
    localparam int INDEX_W = index_w(SIZE);

    typedef struct packed {
        logic [INDEX_W-1:0] rd;
        logic [WIDTH-1:0]   data;
    } entry_t;

    logic                                 alu_fire, alu_push, ld_write, fifo_pop;
    logic                                 fifo_full, fifo_empty;
    entry_t                               push_entry, fifo_head;
    logic [FIFO_DEPTH-1:0]                ent_valid;
    logic [FIFO_DEPTH-1:0][INDEX_W-1:0]   ent_rd;
    wb_src_e                              wr_src, nxt_src;
    logic [INDEX_W-1:0]                   wr_index, nxt_index;
    logic [WIDTH-1:0]                     wr_data, nxt_data;
    logic [SIZE-1:1]                      sb, sb_next;
    logic                                 perr, err_now;
    logic                                 rf_wr_en;
    logic [1:0]                           in_flight;

    assign bus.alu_ready = !fifo_full;
    assign alu_fire      = bus.alu_valid && !fifo_full;
    assign alu_push      = alu_fire && (bus.alu_rd != '0);
    assign ld_write      = bus.ld_resp_valid && (bus.ld_resp_rd != '0);
    assign push_entry    = '{rd: bus.alu_rd, data: bus.alu_data};

    rf_wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .INDEX_W (INDEX_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (alu_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    // Port arbitration: a load response to x0 is consumed without a write,
    // which also leaves the port free for the FIFO that cycle.
    always_comb begin
        nxt_src   = WB_NONE;
        nxt_index = bus.ld_resp_rd;
        nxt_data  = bus.ld_resp_data;
        fifo_pop  = 1'b0;
        if (ld_write) begin
            nxt_src = WB_LOAD;
        end else if (!fifo_empty) begin
            nxt_src   = WB_ALU;
            fifo_pop  = 1'b1;
            nxt_index = fifo_head.rd;
            nxt_data  = fifo_head.data;
        end
    end

    // Scoreboard update; the issue is applied after the clear so that a
    // same-index issue and response in one cycle leaves the bit set.
    always_comb begin
        sb_next = sb;
        err_now = 1'b0;
        if (bus.ld_resp_valid && bus.ld_resp_rd != '0) begin
            if (!sb[bus.ld_resp_rd]) err_now = 1'b1;
            sb_next[bus.ld_resp_rd] = 1'b0;
        end
        if (bus.ld_issue_valid && bus.ld_issue_rd != '0) begin
            if (sb[bus.ld_issue_rd]) err_now = 1'b1;
            sb_next[bus.ld_issue_rd] = 1'b1;
        end
        if (alu_push && sb[bus.alu_rd]) err_now = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_src   <= WB_NONE;
            wr_index <= '0;
            wr_data  <= '0;
            sb       <= '0;
            perr     <= 1'b0;
        end else begin
            wr_src <= nxt_src;
            if (nxt_src != WB_NONE) begin
                wr_index <= nxt_index;
                wr_data  <= nxt_data;
            end
            sb   <= sb_next;
            perr <= perr | err_now;
        end
    end

    assign rf_wr_en        = (wr_src != WB_NONE);
    assign bus.rf_wr_en    = rf_wr_en;
    assign bus.rf_wr_index = wr_index;
    assign bus.rf_wr_data  = wr_data;
    assign bus.proto_err   = perr;

`ifdef RF_WB_BYPASS_EN
    // The in-flight write is forwarded instead of stalling on it.
    assign in_flight = '0;
    assign bus.rs1_data = (rf_wr_en && wr_index == bus.rs1_index && bus.rs1_index != '0)
                          ? wr_data : bus.rf_rd1_data;
    assign bus.rs2_data = (rf_wr_en && wr_index == bus.rs2_index && bus.rs2_index != '0)
                          ? wr_data : bus.rf_rd2_data;
`else
    // The register file commits only at the end of the write cycle.
    assign in_flight[0] = rf_wr_en && (wr_index == bus.rs1_index);
    assign in_flight[1] = rf_wr_en && (wr_index == bus.rs2_index);
`endif

    function automatic logic is_busy(
        input logic [INDEX_W-1:0]                 idx,
        input logic [SIZE-1:1]                    pend,
        input logic [FIFO_DEPTH-1:0]              vld,
        input logic [FIFO_DEPTH-1:0][INDEX_W-1:0] rds,
        input logic                               fly
    );
        logic hit;
        hit = 1'b0;
        if (idx != '0) begin
            hit = pend[idx] | fly;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (vld[i] && rds[i] == idx) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign bus.rs1_busy = is_busy(bus.rs1_index, sb, ent_valid, ent_rd, in_flight[0]);
    assign bus.rs2_busy = is_busy(bus.rs2_index, sb, ent_valid, ent_rd, in_flight[1]);

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_ctrl
// Directed scenarios plus a randomized run against a queue-based reference
// model of the writeback controller.
// ---------------------------------------------------------------------------
module tb_rf_writeback_ctrl;

    localparam int WIDTH = 32;
    localparam int SIZE  = 32;
    localparam int DEPTH = 4;
`ifdef RF_WB_BYPASS_EN
    localparam bit INFLIGHT = 1'b0;
`else
    localparam bit INFLIGHT = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_writeback_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    rf_writeback_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          msb[SIZE];
    bit          m_en;
    int          m_idx;
    logic [31:0] m_data;
    bit          m_perr;

    task automatic model_reset();
        mq.delete();
        foreach (msb[i]) msb[i] = 1'b0;
        m_en = 1'b0; m_idx = 0; m_data = '0; m_perr = 1'b0;
    endtask

    // Applies one clock edge worth of the current inputs to the model.
    task automatic model_step();
        int   ard, ird, rrd;
        bit   fire, ldw;
        ent_t e;
        ard  = int'(bus.alu_rd);
        ird  = int'(bus.ld_issue_rd);
        rrd  = int'(bus.ld_resp_rd);
        fire = bus.alu_valid && (mq.size() < DEPTH);
        ldw  = bus.ld_resp_valid && rrd != 0;
        if (ldw && !msb[rrd]) m_perr = 1'b1;
        if (bus.ld_issue_valid && ird != 0 && msb[ird]) m_perr = 1'b1;
        if (fire && ard != 0 && msb[ard]) m_perr = 1'b1;
        if (ldw) begin
            m_en = 1'b1; m_idx = rrd; m_data = bus.ld_resp_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_en = 1'b1; m_idx = e.rd; m_data = e.data;
        end else begin
            m_en = 1'b0;
        end
        if (fire && ard != 0) mq.push_back('{ard, bus.alu_data});
        if (ldw) msb[rrd] = 1'b0;
        if (bus.ld_issue_valid && ird != 0) msb[ird] = 1'b1;
    endtask

    function automatic bit model_busy(int idx);
        if (idx == 0) return 1'b0;
        if (msb[idx]) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == idx) return 1'b1;
        if (INFLIGHT && m_en && m_idx == idx) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_issue_valid = 1'b0; bus.ld_issue_rd = '0;
        bus.ld_resp_valid = 1'b0; bus.ld_resp_rd = '0; bus.ld_resp_data = '0;
        bus.rs1_index = '0; bus.rs2_index = '0;
`ifdef RF_WB_BYPASS_EN
        bus.rf_rd1_data = $urandom; bus.rf_rd2_data = $urandom;
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.rf_wr_en); end
        checks++; if (bus.rf_wr_index !== 5'd0) begin errors++; $display("FAIL reset_wr_index: got %0d expected 0", bus.rf_wr_index); end
        checks++; if (bus.rf_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", bus.rf_wr_data); end
        checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", bus.proto_err); end
        reset = 1'b0;
        model_reset();
        bus.rs1_index = 5'd5; bus.rs2_index = 5'd31;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b expected 1", bus.alu_ready); end
        checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", bus.rs1_busy, bus.rs2_busy); end
        tick();
    endtask

    task automatic test_alu_only();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234; bus.rs1_index = 5'd5;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_c0_ready: got %b expected 1", bus.alu_ready); end
        tick();
        idle_inputs(); bus.rs1_index = 5'd5; #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL alu_c1_busy: got %b expected 1", bus.rs1_busy); end
        checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL alu_c1_wr_en: got %b expected 0", bus.rf_wr_en); end
        tick();
        #1;
        checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'd5 || bus.rf_wr_data !== 32'h1234)
            begin errors++; $display("FAIL alu_c2_write: got en=%b idx=%0d data=%h expected en=1 idx=5 data=1234", bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data); end
        checks++; if (bus.rs1_busy !== INFLIGHT) begin errors++; $display("FAIL alu_c2_busy: got %b expected %b", bus.rs1_busy, INFLIGHT); end
        tick();
        #1;
        checks++; if (bus.rs1_busy !== 1'b0 || bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL alu_c3_idle: got busy=%b en=%b expected 0 0", bus.rs1_busy, bus.rf_wr_en); end
        tick();
    endtask

    task automatic test_load_priority();
        apply_reset();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd3;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7777;
        tick();
        idle_inputs();
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd3; bus.ld_resp_data = 32'hAAAA;
        #1;
        checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL ldpri_c1_wr_en: got %b expected 0", bus.rf_wr_en); end
        tick();
        idle_inputs(); #1;
        checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'd3 || bus.rf_wr_data !== 32'hAAAA)
            begin errors++; $display("FAIL ldpri_load_first: got en=%b idx=%0d data=%h expected en=1 idx=3 data=aaaa", bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data); end
        tick();
        #1;
        checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'd7 || bus.rf_wr_data !== 32'h7777)
            begin errors++; $display("FAIL ldpri_alu_next: got en=%b idx=%0d data=%h expected en=1 idx=7 data=7777", bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data); end
        tick();
        #1;
        checks++; if (bus.rf_wr_en !== 1'b0 || bus.proto_err !== 1'b0) begin errors++; $display("FAIL ldpri_end: got en=%b perr=%b expected 0 0", bus.rf_wr_en, bus.proto_err); end
        tick();
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            idle_inputs(); bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'(20 + k);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + k); bus.alu_data = 32'h100 + k;
            bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'(20 + k); bus.ld_resp_data = 32'h200 + k;
            #1;
            checks++; if (bus.alu_ready !== (k < 4)) begin errors++; $display("FAIL full_ready_push%0d: got %b expected %b", k, bus.alu_ready, (k < 4)); end
            tick();
        end
        idle_inputs(); #1;
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at_pop: got %b expected 0", bus.alu_ready); end
        checks++; if (bus.rf_wr_index !== 5'd24 || bus.rf_wr_data !== 32'h204) begin errors++; $display("FAIL full_last_load: got idx=%0d data=%h expected idx=24 data=204", bus.rf_wr_index, bus.rf_wr_data); end
        tick();
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", bus.alu_ready); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin tick(); #1; end
            checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'(10 + k) || bus.rf_wr_data !== 32'h100 + k)
                begin errors++; $display("FAIL full_drain%0d: got en=%b idx=%0d data=%h expected en=1 idx=%0d data=%h", k, bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data, 10 + k, 32'h100 + k); end
        end
        tick(); #1;
        checks++; if (bus.rf_wr_en !== 1'b0 || bus.proto_err !== 1'b0) begin errors++; $display("FAIL full_end: got en=%b perr=%b expected 0 0", bus.rf_wr_en, bus.proto_err); end
        tick();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        tick();
        for (int c = 1; c <= 5; c++) begin
            idle_inputs(); bus.rs1_index = 5'd9;
            if (c == 5) begin bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd9; bus.ld_resp_data = 32'hBEEF; end
            #1;
            checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_c%0d: got %b expected 1", c, bus.rs1_busy); end
            tick();
        end
        idle_inputs(); bus.rs1_index = 5'd9; #1;
        checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'd9 || bus.rf_wr_data !== 32'hBEEF)
            begin errors++; $display("FAIL sb_write: got en=%b idx=%0d data=%h expected en=1 idx=9 data=beef", bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data); end
        checks++; if (bus.rs1_busy !== INFLIGHT) begin errors++; $display("FAIL sb_busy_write: got %b expected %b", bus.rs1_busy, INFLIGHT); end
        tick();
        #1;
        checks++; if (bus.rs1_busy !== 1'b0 || bus.proto_err !== 1'b0) begin errors++; $display("FAIL sb_end: got busy=%b perr=%b expected 0 0", bus.rs1_busy, bus.proto_err); end
        tick();
    endtask

    task automatic test_errors();
        // Response to an idle destination: flagged, data still written.
        apply_reset();
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd4; bus.ld_resp_data = 32'h4444;
        tick();
        idle_inputs(); #1;
        checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL err_idle_resp: got %b expected 1", bus.proto_err); end
        checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'd4 || bus.rf_wr_data !== 32'h4444)
            begin errors++; $display("FAIL err_idle_resp_write: got en=%b idx=%0d data=%h expected en=1 idx=4 data=4444", bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data); end
        repeat (3) tick();
        #1;
        checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.proto_err); end
        // Double issue.
        apply_reset();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd6;
        tick();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd6; #1;
        checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL err_first_issue: got %b expected 0", bus.proto_err); end
        tick();
        idle_inputs(); #1;
        checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL err_double_issue: got %b expected 1", bus.proto_err); end
        // WAW against a pending load: flagged, result still written.
        apply_reset();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd8;
        tick();
        idle_inputs(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h88;
        tick();
        idle_inputs(); #1;
        checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL err_waw: got %b expected 1", bus.proto_err); end
        tick(); #1;
        checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_index !== 5'd8 || bus.rf_wr_data !== 32'h88)
            begin errors++; $display("FAIL err_waw_write: got en=%b idx=%0d data=%h expected en=1 idx=8 data=88", bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data); end
        // Same-index issue and response in one cycle: the set wins.
        apply_reset();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd11;
        tick();
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd11;
        bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'd11; bus.ld_resp_data = 32'hB0B;
        tick();
        idle_inputs(); bus.rs1_index = 5'd11;
        tick(); tick(); #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b expected 1", bus.rs1_busy); end
        tick();
    endtask

    task automatic test_x0_reset();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD; #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", bus.alu_ready); end
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_no_write%0d: got %b expected 0", c, bus.rf_wr_en); end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'(20 + k);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(15 + k); bus.alu_data = 32'h500 + k;
            bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'(20 + k); bus.ld_resp_data = 32'h600 + k;
            tick();
        end
        idle_inputs(); bus.rs1_index = 5'd15; bus.rs2_index = 5'd16; #1;
        checks++; if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin errors++; $display("FAIL rst_queued: got %b%b expected 11", bus.rs1_busy, bus.rs2_busy); end
        #1 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_async_wr_en: got %b expected 0", bus.rf_wr_en); end
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.alu_ready); end
        checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL rst_fifo_busy: got %b%b expected 00", bus.rs1_busy, bus.rs2_busy); end
        bus.rs1_index = 5'd22; #1;
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL rst_sb_busy: got %b expected 0", bus.rs1_busy); end
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_no_write%0d: got %b expected 0", c, bus.rf_wr_en); end
        end
        tick();
    endtask

    task automatic test_random();
        int ard, ird, rrd, r1, r2;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle_inputs();
            ard = int'($urandom_range(0, SIZE - 1));
            if (msb[ard]) ard = 0;
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.alu_rd    = 5'(ard);
            bus.alu_data  = $urandom;
            ird = int'($urandom_range(1, SIZE - 1));
            if ($urandom_range(0, 3) == 0 && !msb[ird]) begin
                bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'(ird);
            end
            rrd = int'($urandom_range(0, SIZE - 1));
            if ($urandom_range(0, 2) == 0 && (rrd == 0 || msb[rrd])) begin
                bus.ld_resp_valid = 1'b1; bus.ld_resp_rd = 5'(rrd); bus.ld_resp_data = $urandom;
            end
            r1 = int'($urandom_range(0, SIZE - 1));
            r2 = (mq.size() > 0) ? mq[0].rd : int'($urandom_range(0, SIZE - 1));
            bus.rs1_index = 5'(r1); bus.rs2_index = 5'(r2);
            #1;
            checks++; if (bus.alu_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, bus.alu_ready, (mq.size() < DEPTH)); end
            checks++; if (bus.rs1_busy !== model_busy(r1)) begin errors++; $display("FAIL rnd_rs1_busy@%0d: idx=%0d got %b expected %b", cyc, r1, bus.rs1_busy, model_busy(r1)); end
            checks++; if (bus.rs2_busy !== model_busy(r2)) begin errors++; $display("FAIL rnd_rs2_busy@%0d: idx=%0d got %b expected %b", cyc, r2, bus.rs2_busy, model_busy(r2)); end
            checks++; if (bus.rf_wr_en !== m_en || (m_en && (bus.rf_wr_index !== 5'(m_idx) || bus.rf_wr_data !== m_data)))
                begin errors++; $display("FAIL rnd_write@%0d: got en=%b idx=%0d data=%h expected en=%b idx=%0d data=%h", cyc, bus.rf_wr_en, bus.rf_wr_index, bus.rf_wr_data, m_en, m_idx, m_data); end
            checks++; if (bus.proto_err !== m_perr) begin errors++; $display("FAIL rnd_perr@%0d: got %b expected %b", cyc, bus.proto_err, m_perr); end
`ifdef RF_WB_BYPASS_EN
            checks++; if (bus.rs1_data !== ((m_en && m_idx == r1 && r1 != 0) ? m_data : bus.rf_rd1_data))
                begin errors++; $display("FAIL rnd_rs1_data@%0d: got %h", cyc, bus.rs1_data); end
`endif
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_alu_only();
        test_load_priority();
        test_fifo_full();
        test_scoreboard();
        test_errors();
        test_x0_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
